// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit controller.
// Frame state encoding, bit timing and divider defaults live here.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_e;

   localparam int          TICKS_PER_BIT          = 16;
   localparam int          APPLY_CYCLES           = 2;
   localparam logic [15:0] UART_DIV_DEF           = 16'd27;
   localparam logic [4:0]  UART_FRAG_TOTAL_DEF    = 5'd2;
   localparam logic [3:0]  UART_FRAG_I_DEF        = 4'd7;

   typedef struct packed {
      logic [15:0] div;
      logic [4:0]  frag_total;
      logic [3:0]  frag_i;
      logic        parity_en;
      logic        parity_odd;
      logic        stop2;
   } uart_cfg_t;

   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte push handshake and configuration strobe bus of the UART transmit controller.
interface uart_tx_ctrl_if;

   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        cfg_we;
   logic [15:0] cfg_div;
   logic [4:0]  cfg_frag_total;
   logic [3:0]  cfg_frag_i;
   logic        cfg_parity_en;
   logic        cfg_parity_odd;
   logic        cfg_stop2;

   modport master (
      output tx_valid, tx_data, cfg_we, cfg_div, cfg_frag_total, cfg_frag_i,
             cfg_parity_en, cfg_parity_odd, cfg_stop2,
      input  tx_ready
   );

   modport slave (
      input  tx_valid, tx_data, cfg_we, cfg_div, cfg_frag_total, cfg_frag_i,
             cfg_parity_en, cfg_parity_odd, cfg_stop2,
      output tx_ready
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// 8-bit wide transmit FIFO with first-word fall-through read data.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  logic [7:0] wr_data,
   input  logic       pop,
   output logic [7:0] rd_data,
   output logic       empty,
   output logic       full
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   // Flags come from the registered count only, so a same-cycle pop never frees a slot early.
   assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: buffers bytes, serialises frames on clk_sample ticks and
// applies shadowed baud-divider settings to uart_clk_div only between frames.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int          FIFO_DEPTH     = 8,
   parameter logic [15:0] DIV_DEF        = UART_DIV_DEF,
   parameter logic [4:0]  FRAG_TOTAL_DEF = UART_FRAG_TOTAL_DEF,
   parameter logic [3:0]  FRAG_I_DEF     = UART_FRAG_I_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_tx_ctrl_if.slave bus,
   input  logic          clk_sample,
   output logic [15:0]   uart_clk_div,
   output logic [4:0]    uart_clk_frag_total,
   output logic [3:0]    uart_clk_frag_i,
   output logic          div_rst_n,
   output logic          uart_tx,
   output logic          busy,
   output logic          cfg_pending
);

   tx_state_e  state;
   tx_state_e  state_nxt;
   uart_cfg_t  shadow;
   logic       sample_d;
   logic       tick;
   logic       bit_end;
   logic       in_frame;
   logic [3:0] tick_cnt;
   logic [2:0] bit_cnt;
   logic       apply_cnt;
   logic [7:0] shift_reg;
   logic [7:0] frame_data;
   logic       frame_par_en;
   logic       frame_odd;
   logic       frame_stop2;
   logic       fifo_pop;
   logic       fifo_empty;
   logic       fifo_full;
   logic [7:0] fifo_rd;

   uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (bus.tx_valid),
      .wr_data (bus.tx_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

   assign bus.tx_ready = ~fifo_full;

   // Rising edge of the oversample clock; suppressed while the divider is held in reset.
   assign tick     = clk_sample & ~sample_d & div_rst_n;
   assign in_frame = (state == ST_START) || (state == ST_DATA) ||
                     (state == ST_PARITY) || (state == ST_STOP);
   assign bit_end  = tick && (tick_cnt == 4'(TICKS_PER_BIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (cfg_pending)      state_nxt = ST_APPLY;
            else if (!fifo_empty) state_nxt = ST_START;
         end
         ST_APPLY: begin
            if (apply_cnt == 1'(APPLY_CYCLES - 1)) state_nxt = ST_IDLE;
         end
         ST_START: begin
            if (bit_end) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end && bit_cnt == 3'd7) state_nxt = frame_par_en ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (bit_end) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            // bit_cnt enters STOP at zero and counts completed stop bits.
            if (bit_end && (!frame_stop2 || bit_cnt == 3'd1)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      uart_tx   = 1'b1;
      div_rst_n = rst_n & (state != ST_APPLY);
      fifo_pop  = (state == ST_IDLE) && !cfg_pending && !fifo_empty;
      busy      = (state != ST_IDLE) || !fifo_empty;
      case (state)
         ST_START:  uart_tx = 1'b0;
         ST_DATA:   uart_tx = shift_reg[0];
         ST_PARITY: uart_tx = parity_bit(frame_data, frame_odd);
         default:   uart_tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_d     <= 1'b0;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         apply_cnt    <= 1'b0;
         frame_par_en <= 1'b0;
         frame_odd    <= 1'b0;
         frame_stop2  <= 1'b0;
      end else begin
         sample_d  <= clk_sample;
         apply_cnt <= (state == ST_APPLY) ? apply_cnt + 1'b1 : 1'b0;
         if (fifo_pop) begin
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            frame_par_en <= shadow.parity_en;
            frame_odd    <= shadow.parity_odd;
            frame_stop2  <= shadow.stop2;
         end else if (tick && in_frame) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (bit_end && (state == ST_DATA || state == ST_STOP)) bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_pop) begin
         shift_reg  <= fifo_rd;
         frame_data <= fifo_rd;
      end else if (bit_end && state == ST_DATA) begin
         shift_reg <= {1'b0, shift_reg[7:1]};
      end
   end

   // Shadow captures every strobe; the divider only sees it during the first APPLY cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow              <= '{div: DIV_DEF, frag_total: FRAG_TOTAL_DEF, frag_i: FRAG_I_DEF,
                                  parity_en: 1'b0, parity_odd: 1'b0, stop2: 1'b0};
         cfg_pending         <= 1'b0;
         uart_clk_div        <= DIV_DEF;
         uart_clk_frag_total <= FRAG_TOTAL_DEF;
         uart_clk_frag_i     <= FRAG_I_DEF;
      end else begin
         if (bus.cfg_we) begin
            shadow <= '{div: bus.cfg_div, frag_total: bus.cfg_frag_total,
                        frag_i: bus.cfg_frag_i, parity_en: bus.cfg_parity_en,
                        parity_odd: bus.cfg_parity_odd, stop2: bus.cfg_stop2};
         end
         if (bus.cfg_we)                                cfg_pending <= 1'b1;
         else if (state == ST_APPLY && apply_cnt == 1'b1) cfg_pending <= 1'b0;
         if (state == ST_APPLY && apply_cnt == 1'b0) begin
            uart_clk_div        <= shadow.div;
            uart_clk_frag_total <= shadow.frag_total;
            uart_clk_frag_i     <= shadow.frag_i;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-format vector table, FIFO fill, mid-frame config and reset.
module tb_uart_tx_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clk_sample = 1'b0;
   logic [15:0] uart_clk_div;
   logic [4:0]  uart_clk_frag_total;
   logic [3:0]  uart_clk_frag_i;
   logic        div_rst_n;
   logic        uart_tx;
   logic        busy;
   logic        cfg_pending;

   uart_tx_ctrl_if bus();

   uart_tx_ctrl dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .bus                 (bus),
      .clk_sample          (clk_sample),
      .uart_clk_div        (uart_clk_div),
      .uart_clk_frag_total (uart_clk_frag_total),
      .uart_clk_frag_i     (uart_clk_frag_i),
      .div_rst_n           (div_rst_n),
      .uart_tx             (uart_tx),
      .busy                (busy),
      .cfg_pending         (cfg_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       par_en;
      logic       odd;
      logic       stop2;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       par_en;
      logic       odd;
      logic       stop2;
      logic       exp_par;
      int         exp_clks;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[7];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   bit   cs_d = 1'b0;
   bit   tick_b = 1'b0;
   int   frames_done = 0;
   int   gap_cnt = 0;
   int   last_gap = 0;
   int   gap1_cnt = 0;
   int   last_len = 0;
   logic last_par = 1'b0;
   logic cur_par_en = 1'b0;
   logic cur_odd = 1'b0;
   logic cur_stop2 = 1'b0;

   // Oversample clock: 2 clk high, 2 clk low.
   initial begin
      int ph = 0;
      forever begin
         @(posedge clk);
         #1;
         ph = (ph + 1) % 4;
         clk_sample = (ph < 2);
      end
   end

   always @(posedge clk) begin
      cs_d   <= clk_sample;
      tick_b <= clk_sample & ~cs_d;
      cyc    <= cyc + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Checks the line holds one level for 16 bench ticks; entered at the first negedge of the bit.
   task automatic mon_bit(input logic expv, input string nm, output logic first_v, output bit aborted);
      int n = 0;
      bit bad = 0;
      aborted = 0;
      first_v = uart_tx;
      while (n < 16) begin
         if (!rst_n) begin
            aborted = 1;
            return;
         end
         if (uart_tx !== expv) bad = 1;
         @(negedge clk);
         if (tick_b) n++;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL %s: line started at %b and did not hold required %b for 16 ticks", nm, first_v, expv);
      end
   endtask

   initial begin : monitor
      exp_t       e;
      logic       v;
      bit         ab;
      int         t0;
      logic [7:0] sh;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            gap_cnt = 0;
         end else if (uart_tx === 1'b0) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame: start bit seen with empty scoreboard, required none");
               while (rst_n && uart_tx === 1'b0) @(negedge clk);
               gap_cnt = 0;
            end else begin
               e = sb.pop_front();
               last_gap = gap_cnt;
               if (gap_cnt == 1) gap1_cnt++;
               sh = e.data;
               mon_bit(1'b0, "start_bit", v, ab);
               t0 = cyc;
               for (int i = 0; i < 8 && !ab; i++) mon_bit(sh[i], "data_bit", v, ab);
               if (!ab && e.par_en) begin
                  mon_bit((^e.data) ^ e.odd, "parity_bit", v, ab);
                  last_par = v;
               end
               if (!ab) mon_bit(1'b1, "stop_bit", v, ab);
               if (!ab && e.stop2) mon_bit(1'b1, "stop_bit2", v, ab);
               if (!ab) begin
                  last_len = cyc - t0;
                  frames_done++;
                  gap_cnt = 1;
               end else begin
                  gap_cnt = 0;
               end
            end
         end else begin
            gap_cnt++;
         end
      end
   end

   task automatic push_byte(input logic [7:0] d, output bit acc);
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      acc = bus.tx_ready;
      @(posedge clk);
      if (acc) sb.push_back('{data: d, par_en: cur_par_en, odd: cur_odd, stop2: cur_stop2});
      #1 bus.tx_valid = 1'b0;
   endtask

   task automatic do_cfg(input logic [15:0] d, input logic [4:0] ft, input logic [3:0] fi,
                         input logic pe, input logic po, input logic s2);
      @(negedge clk);
      bus.cfg_div        = d;
      bus.cfg_frag_total = ft;
      bus.cfg_frag_i     = fi;
      bus.cfg_parity_en  = pe;
      bus.cfg_parity_odd = po;
      bus.cfg_stop2      = s2;
      bus.cfg_we         = 1'b1;
      @(negedge clk);
      bus.cfg_we = 1'b0;
      cur_par_en = pe;
      cur_odd    = po;
      cur_stop2  = s2;
      chk("cfg_pending_set", cfg_pending, 1);
   endtask

   task automatic wait_pending_clear(input int lim);
      int n = 0;
      while (cfg_pending && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("cfg_pending_cleared", cfg_pending, 0);
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      @(negedge clk);
      while (busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("busy_drops", busy, 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int f0;
      int g0;
      int acc_n;
      int n;
      int lowc;

      vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 576};
      vecs[1] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 704};
      vecs[2] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 640};
      vecs[3] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 704};
      vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 640};
      vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 640};
      vecs[6] = '{8'h7E, 1'b1, 1'b1, 1'b0, 1'b1, 640};

      bus.tx_valid = 0; bus.tx_data = 0; bus.cfg_we = 0; bus.cfg_div = 0;
      bus.cfg_frag_total = 0; bus.cfg_frag_i = 0; bus.cfg_parity_en = 0;
      bus.cfg_parity_odd = 0; bus.cfg_stop2 = 0;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_div", uart_clk_div, 27);
      chk("rst_frag_total", uart_clk_frag_total, 2);
      chk("rst_frag_i", uart_clk_frag_i, 7);
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_tx_ready", bus.tx_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_div_rst_n", div_rst_n, 1);
      chk("rst_cfg_pending", cfg_pending, 0);

      // Frame formats from the vector table
      for (int i = 0; i < 7; i++) begin
         do_cfg(16'd27, 5'd2, 4'd7, vecs[i].par_en, vecs[i].odd, vecs[i].stop2);
         wait_pending_clear(20);
         f0 = frames_done;
         push_byte(vecs[i].data, acc);
         chk("vec_push_accepted", acc, 1);
         wait_idle(2000);
         @(negedge clk);
         chk("vec_frame_done", frames_done, f0 + 1);
         chk("vec_frame_clks", last_len, vecs[i].exp_clks);
         if (vecs[i].par_en) chk("vec_parity", last_par, vecs[i].exp_par);
      end

      // FIFO fill: one byte is popped on the second push cycle, so nine are accepted.
      do_cfg(16'd27, 5'd2, 4'd7, 1'b0, 1'b0, 1'b0);
      wait_pending_clear(20);
      f0 = frames_done;
      g0 = gap1_cnt;
      acc_n = 0;
      @(negedge clk);
      while (acc_n < 12 && bus.tx_ready) begin
         bus.tx_valid = 1'b1;
         bus.tx_data  = 8'h40 + 8'(acc_n);
         @(posedge clk);
         sb.push_back('{data: 8'h40 + 8'(acc_n), par_en: 1'b0, odd: 1'b0, stop2: 1'b0});
         acc_n++;
         @(negedge clk);
      end
      chk("fifo_accepted", acc_n, 9);
      chk("fifo_full_ready", bus.tx_ready, 0);
      bus.tx_data = 8'hEE;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      chk("fifo_still_full", bus.tx_ready, 0);
      wait_idle(9 * 700);
      @(negedge clk);
      chk("fifo_frames", frames_done, f0 + 9);
      chk("fifo_gaps_one_clk", gap1_cnt, g0 + 8);

      // Configuration written during DATA of byte 0, byte 1 queued
      f0 = frames_done;
      push_byte(8'h5A, acc);
      push_byte(8'hC3, acc);
      repeat (200) @(negedge clk);
      do_cfg(16'd100, 5'd3, 4'd4, 1'b0, 1'b0, 1'b0);
      chk("midcfg_div_held", uart_clk_div, 27);
      n = 0;
      while (div_rst_n && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("midcfg_apply_seen", div_rst_n, 0);
      chk("midcfg_after_stop", frames_done, f0 + 1);
      chk("midcfg_tx_idle", uart_tx, 1);
      lowc = 0;
      while (!div_rst_n && lowc < 10) begin
         lowc++;
         @(negedge clk);
      end
      chk("apply_cycles", lowc, 2);
      chk("midcfg_div", uart_clk_div, 100);
      chk("midcfg_frag_total", uart_clk_frag_total, 3);
      chk("midcfg_frag_i", uart_clk_frag_i, 4);
      chk("midcfg_pending_clear", cfg_pending, 0);
      wait_idle(2000);
      @(negedge clk);
      chk("midcfg_frames", frames_done, f0 + 2);
      chk("midcfg_gap", last_gap, 4);

      // Asynchronous reset during DATA
      push_byte(8'h96, acc);
      push_byte(8'h69, acc);
      repeat (150) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_uart_tx", uart_tx, 1);
      chk("arst_tx_ready", bus.tx_ready, 1);
      chk("arst_busy", busy, 0);
      sb.delete();
      cur_par_en = 0; cur_odd = 0; cur_stop2 = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_div", uart_clk_div, 27);
      chk("arst_frag_total", uart_clk_frag_total, 2);
      chk("arst_frag_i", uart_clk_frag_i, 7);
      chk("arst_div_rst_n", div_rst_n, 1);
      chk("arst_cfg_pending", cfg_pending, 0);
      f0 = frames_done;
      push_byte(8'h3C, acc);
      wait_idle(2000);
      @(negedge clk);
      chk("post_rst_frame", frames_done, f0 + 1);
      chk("post_rst_clks", last_len, 576);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit controller that sits between the bus-side register block and the existing uart_clk_div. It holds shadow baud-divider settings and applies them to the divider only between frames, pulsing the divider's reset at the same time. It buffers outgoing bytes in a small FIFO and serialises each byte onto the TX line, using rising edges of the divider's 16x oversample output clk_sample as bit-timing ticks.

Parameters:
FIFO_DEPTH, 8, transmit FIFO entries; must be a power of 2 and at least 2.
DIV_DEF, 16'd27, reset value of uart_clk_div.
FRAG_TOTAL_DEF, 5'd2, reset value of uart_clk_frag_total.
FRAG_I_DEF, 4'd7, reset value of uart_clk_frag_i.

Ports:
clk  in  1  system clock; the divider runs on the same clock.
rst_n  in  1  asynchronous, active-low reset.
cfg_we  in  1  one-cycle strobe; captures all cfg_* inputs into the shadow registers.
cfg_div  in  16  new integer divisor.
cfg_frag_total  in  5  new fractional add count.
cfg_frag_i  in  4  new fractional add interval.
cfg_parity_en  in  1  enables the parity bit.
cfg_parity_odd  in  1  1 = odd parity, 0 = even parity.
cfg_stop2  in  1  1 = two stop bits, 0 = one stop bit.
tx_valid  in  1  byte push request.
tx_data  in  8  byte to transmit.
tx_ready  out  1  FIFO not full.
clk_sample  in  1  16x oversample clock from the divider, synchronous to clk.
uart_clk_div  out  16  to the divider.
uart_clk_frag_total  out  5  to the divider.
uart_clk_frag_i  out  4  to the divider.
div_rst_n  out  1  divider reset, active-low; ANDed with rst_n at the top level.
uart_tx  out  1  serial output; idles high.
busy  out  1  high when the FSM is not in IDLE or the FIFO is not empty.
cfg_pending  out  1  shadow settings captured but not yet applied.

Behaviour:
Reset values:
- uart_tx=1, tx_ready=1, busy=0, cfg_pending=0, div_rst_n=1.
- Divider outputs take DIV_DEF, FRAG_TOTAL_DEF and FRAG_I_DEF.
- Parity and stop settings are 0. The FIFO is empty.
- Reset is asynchronous: asserting it mid-frame drives uart_tx=1 immediately and flushes the FIFO.

Tick generation:
- Register sample_d <= clk_sample.
- tick = clk_sample & ~sample_d.
- tick is forced to 0 while div_rst_n=0.

FIFO:
- A push is accepted when tx_valid && tx_ready.
- tx_ready = (count != FIFO_DEPTH), computed from the registered count. A pop in the same cycle does not unblock a push on a full FIFO.
- Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Configuration:
- cfg_we latches all cfg_* inputs into shadow registers and sets cfg_pending.
- Repeated cfg_we before the settings are applied overwrites the shadow: last write wins.
- Parity and stop settings are also latched per frame at START, so they never change mid-frame.

FSM states: IDLE, APPLY, START, DATA, PARITY, STOP.
- IDLE: if cfg_pending, go to APPLY. Apply has priority over starting a frame.
  - Otherwise, if the FIFO is non-empty, pop into shift_reg, clear tick_cnt and bit_cnt, and go to START on the next clk.
- APPLY: lasts exactly 2 clk cycles.
  - div_rst_n=0 for both cycles.
  - Divider outputs load from the shadow on the first cycle.
  - cfg_pending clears on the second cycle, unless cfg_we fires in that same cycle, in which case it stays set.
  - Then return to IDLE.
- START: uart_tx=0 for 16 ticks, then go to DATA.
- DATA: uart_tx = shift_reg[0], LSB first.
  - Each bit lasts 16 ticks; shift right and increment bit_cnt at the end of each bit.
  - After bit 7, go to PARITY if parity is enabled, otherwise to STOP.
- PARITY: uart_tx = ^data XOR cfg_parity_odd, held for 16 ticks.
- STOP: uart_tx=1 for 16 ticks, or 32 ticks when cfg_stop2 is set; then go to IDLE.

Timing:
- tick_cnt is 4 bits; a bit ends on the tick where tick_cnt==15, and tick_cnt wraps to 0.
- Back-to-back frames have exactly one idle clk cycle between the end of STOP and the start of START.
- cfg_we during a frame does not disturb the frame; the settings are applied after STOP.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_e enum;
  - TICKS_PER_BIT=16;
  - APPLY_CYCLES=2;
  - the default divider constants.
- Sub-module uart_tx_fifo (parameterised depth, 8-bit wide) contains the FIFO.

Test Plan:
1. Reset values: release reset -> uart_div=27, frag_total=2, frag_i=7, uart_tx=1, tx_ready=1, busy=0, div_rst_n=1.
2. Single frame: bench drives clk_sample with period 4 clk (2 high, 2 low); push 0xA5 with 8N1 -> uart_tx sequence 0,1,0,1,0,0,1,0,1,1; each bit lasts 64 clk; busy drops after STOP.
3. Parity and stop bits: odd parity with 2 stop bits, push 0x03 -> parity bit=1, stop high for 128 clk; total frame length 12 bits = 768 clk.
4. FIFO full: push 9 bytes back-to-back with FIFO_DEPTH=8 -> tx_ready low after the 8th accepted push (ignoring pops); all accepted bytes are transmitted in order with 1-clk inter-frame gaps.
5. Config mid-frame: cfg_we with div=100 during DATA of byte 0, with byte 1 queued -> outputs unchanged until STOP ends; APPLY takes 2 clk with div_rst_n=0; byte 1 starts afterwards; cfg_pending goes 1 then 0.
6. Reset mid-frame: assert rst_n=0 during DATA -> uart_tx=1 asynchronously and FIFO empty; after release, the divider outputs are back to their default values.
